// File: rtl/seq_mult4_ctrl.sv
// Sequential 4x4 unsigned shift-and-add multiplier. One rcad addition per cycle
// for four cycles, then an 8-bit product is presented with a one-cycle done pulse.

module rcad (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       m,
    output logic [3:0] s,
    output logic [3:0] c,
    output logic       ov
);

    always_comb begin
        logic carry;
        // NOTE: always_comb assigns every output a default first so no path
        // through the block leaves a signal unassigned (which would infer a latch).
        s     = '0;
        c     = '0;
        carry = m;
        for (int i = 0; i < 4; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
            c[i]  = carry;
        end
    end

    assign ov = c[3] ^ c[2];

endmodule

module seq_mult4_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] acc;
    logic [1:0]       cnt;

    logic [3:0] add_b;
    logic [3:0] add_s;
    logic [3:0] add_c;
    logic       ov_unused;

    assign add_b = q_reg[0] ? m_reg : 4'h0;

    rcad u_rcad (
        .a  (acc),
        .b  (add_b),
        .m  (1'b0),
        .s  (add_s),
        .c  (add_c),
        .ov (ov_unused)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == 2'd3) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_reg   <= '0;
            q_reg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        m_reg <= a;
                        q_reg <= b;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    // {carry,sum,Q} shifted right by one: the dropped bit is Q[0].
                    {acc, q_reg} <= {add_c[3], add_s, q_reg[3:1]};
                    cnt          <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        product <= {add_c[3], add_s, q_reg[3:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
